// File: rtl/instr_sequencer_pkg.sv
// Purpose: shared state encodings and widths for the instruction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_sequencer_pkg;

    localparam int STATE_W   = 3;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    // FETCH through WB count as busy; IDLE and FAULT do not.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
               (s == ST_MEM)   || (s == ST_WB);
    endfunction

endpackage

// File: rtl/instr_sequencer_retire_counter.sv
// Purpose: retired-instruction counter, wraps modulo 2^CNT_W.
// Latency: count reflects an enable one clock after it is sampled.
// Backpressure: none; counts every enabled cycle.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Free-running increment on enable; natural overflow gives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with per-stage write strobes.
// Latency: ALU 4, branch 3, store 4, load 5 cycles plus memory wait cycles; outputs are combinational from state.
// Backpressure: stalls in FETCH on im_ready=0 and in MEM on dm_ready=0; INSTR_SEQ_TIMEOUT_EN bounds those waits.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               halt_req,
    input  logic               is_mem,
    input  logic               is_store,
    input  logic               is_branch,
    input  logic               im_ready,
    input  logic               dm_ready,
    output logic               im_req,
    output logic               ir_we,
    output logic               pc_we,
    output logic               rb_we,
    output logic               dm_req,
    output logic               dm_we,
    output logic               busy,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   retired,
    output logic               fault
);

    state_t cur_st;
    state_t nxt_st;
    state_t bnd_st;
    logic   halt_lat;
    logic   halt_lat_nxt;

`ifdef INSTR_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;

    // The current cycle is the last allowed wait cycle before faulting.
    assign wait_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // A halt seen now or earlier in this instruction ends the run at the boundary.
    assign bnd_st = (halt_lat || halt_req) ? ST_IDLE : ST_FETCH;
    assign state  = cur_st;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_st <= ST_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Next state and strobes; ready arriving on the limit cycle beats the timeout.
    always_comb begin
        nxt_st = cur_st;
        im_req = 1'b0;
        ir_we  = 1'b0;
        pc_we  = 1'b0;
        rb_we  = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        fault  = 1'b0;
        busy   = state_is_busy(cur_st);
        case (cur_st)
            ST_IDLE: begin
                if (start) begin
                    nxt_st = ST_FETCH;
                end
            end
            ST_FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
                    ir_we  = 1'b1;
                    nxt_st = ST_DECODE;
                end
`ifdef INSTR_SEQ_TIMEOUT_EN
                else if (wait_hit) begin
                    nxt_st = ST_FAULT;
                end
`endif
            end
            ST_DECODE: begin
                nxt_st = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem) begin
                    nxt_st = ST_MEM;
                end else if (is_branch) begin
                    pc_we  = 1'b1;
                    nxt_st = bnd_st;
                end else begin
                    nxt_st = ST_WB;
                end
            end
            ST_MEM: begin
                dm_req = 1'b1;
                dm_we  = is_store;
                if (dm_ready) begin
                    if (is_store) begin
                        pc_we  = 1'b1;
                        nxt_st = bnd_st;
                    end else begin
                        nxt_st = ST_WB;
                    end
                end
`ifdef INSTR_SEQ_TIMEOUT_EN
                else if (wait_hit) begin
                    nxt_st = ST_FAULT;
                end
`endif
            end
            ST_WB: begin
                rb_we  = 1'b1;
                pc_we  = 1'b1;
                nxt_st = bnd_st;
            end
            ST_FAULT: begin
`ifdef INSTR_SEQ_TIMEOUT_EN
                fault  = 1'b1;
`else
                nxt_st = ST_IDLE;
`endif
            end
            default: begin
                nxt_st = ST_IDLE;
            end
        endcase
    end

    // Halt latch: armed outside IDLE, cleared whenever IDLE is entered.
    always_comb begin
        halt_lat_nxt = halt_lat;
        if ((cur_st != ST_IDLE) && halt_req) begin
            halt_lat_nxt = 1'b1;
        end
        if (nxt_st == ST_IDLE) begin
            halt_lat_nxt = 1'b0;
        end
    end

    // Halt latch register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            halt_lat <= 1'b0;
        end else begin
            halt_lat <= halt_lat_nxt;
        end
    end

`ifdef INSTR_SEQ_TIMEOUT_EN
    // Wait counter restarts on any state change and counts not-ready cycles in FETCH/MEM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= '0;
        end else if (nxt_st != cur_st) begin
            wait_cnt <= '0;
        end else if (((cur_st == ST_FETCH) && !im_ready) ||
                     ((cur_st == ST_MEM) && !dm_ready)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end
`endif

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (pc_we),
        .count (retired)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose: directed self-checking bench for instr_sequencer with a retire scoreboard.
// Latency: checks each cycle of every instruction plus end-to-end instruction latency.
// Backpressure: exercises im_ready/dm_ready stalls and, with INSTR_SEQ_TIMEOUT_EN, the fault path.
module tb_instr_sequencer;

    localparam int CW   = 4;
    localparam int K_ALU = 0;
    localparam int K_BR  = 1;
    localparam int K_ST  = 2;
    localparam int K_LD  = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          is_mem = 1'b0;
    logic          is_store = 1'b0;
    logic          is_branch = 1'b0;
    logic          im_ready = 1'b0;
    logic          dm_ready = 1'b0;
    logic          im_req;
    logic          ir_we;
    logic          pc_we;
    logic          rb_we;
    logic          dm_req;
    logic          dm_we;
    logic          busy;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic          fault;

    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] sb_q[$];
    logic [CW-1:0] exp_cnt = '0;

    instr_sequencer #(
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .halt_req  (halt_req),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .is_branch (is_branch),
        .im_ready  (im_ready),
        .dm_ready  (dm_ready),
        .im_req    (im_req),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .rb_we     (rb_we),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .busy      (busy),
        .state     (state),
        .retired   (retired),
        .fault     (fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe order: {im_req, ir_we, pc_we, rb_we, dm_req, dm_we}.
    task automatic chk_cyc(input string tag, input logic [2:0] exp_state,
                           input logic exp_busy, input logic [5:0] exp_strb);
        chk({tag, "_state"}, {27'd0, state, busy, fault}, {27'd0, exp_state, exp_busy, 1'b0});
        chk({tag, "_strb"}, {26'd0, im_req, ir_we, pc_we, rb_we, dm_req, dm_we}, {26'd0, exp_strb});
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_seq();
        start = 1'b1;
        #1;
        chk_cyc("idle_start", 3'd0, 1'b0, 6'b000000);
        tick();
        start = 1'b0;
    endtask

    // Drives one instruction starting in FETCH and checks each cycle and the total latency.
    task automatic do_instr(input int kind, input int im_wait, input int dm_wait, input bit halt_dec);
        int   cyc;
        int   base;
        logic st;
        cyc = 0;
        st  = (kind == K_ST);
        case (kind)
            K_BR:    base = 3;
            K_LD:    base = 5;
            default: base = 4;
        endcase
        is_mem    = (kind == K_ST) || (kind == K_LD);
        is_store  = st;
        is_branch = (kind == K_BR);
        for (int i = 0; i < im_wait; i++) begin
            im_ready = 1'b0;
            #1;
            chk_cyc("fetch_wait", 3'd1, 1'b1, 6'b100000);
            tick();
            cyc++;
        end
        im_ready = 1'b1;
        #1;
        chk_cyc("fetch", 3'd1, 1'b1, 6'b110000);
        exp_cnt = exp_cnt + 1'b1;
        sb_q.push_back(exp_cnt);
        tick();
        cyc++;
        im_ready = 1'b0;
        halt_req = halt_dec;
        #1;
        chk_cyc("decode", 3'd2, 1'b1, 6'b000000);
        tick();
        cyc++;
        halt_req = 1'b0;
        #1;
        chk_cyc("exec", 3'd3, 1'b1, (kind == K_BR) ? 6'b001000 : 6'b000000);
        tick();
        cyc++;
        if (is_mem) begin
            for (int i = 0; i < dm_wait; i++) begin
                dm_ready = 1'b0;
                #1;
                chk_cyc("mem_wait", 3'd4, 1'b1, {4'b0000, 1'b1, st});
                tick();
                cyc++;
            end
            dm_ready = 1'b1;
            #1;
            chk_cyc("mem_done", 3'd4, 1'b1, {2'b00, st, 1'b0, 1'b1, st});
            tick();
            cyc++;
            dm_ready = 1'b0;
        end
        if ((kind == K_ALU) || (kind == K_LD)) begin
            #1;
            chk_cyc("wb", 3'd5, 1'b1, 6'b001100);
            tick();
            cyc++;
        end
        chk("latency", cyc, base + im_wait + dm_wait);
        #1;
        if (halt_dec) chk_cyc("boundary_idle", 3'd0, 1'b0, 6'b000000);
        else          chk_cyc("boundary_fetch", 3'd1, 1'b1, 6'b100000);
    endtask

    // Scoreboard: every retire pops the expected count and compares it after the edge.
    initial begin
        logic [CW-1:0] ret_exp;
        forever begin
            @(negedge CLK);
            if ((RST_N === 1'b1) && (pc_we === 1'b1)) begin
                chk("sb_nonempty", {31'd0, (sb_q.size() > 0)}, 32'd1);
                if (sb_q.size() > 0) begin
                    ret_exp = sb_q.pop_front();
                    @(posedge CLK);
                    #1;
                    chk("retired", {28'd0, retired}, {28'd0, ret_exp});
                end
            end
        end
    end

    initial begin
        #3;
        chk_cyc("reset", 3'd0, 1'b0, 6'b000000);
        chk("reset_retired", {28'd0, retired}, 32'd0);
        tick();
        RST_N = 1'b1;
        tick();
        #1;
        chk_cyc("idle_hold", 3'd0, 1'b0, 6'b000000);

        // ALU, stalled load, store, branch, then halt during DECODE.
        start_seq();
        do_instr(K_ALU, 0, 0, 1'b0);
        do_instr(K_LD, 0, 3, 1'b0);
        do_instr(K_ST, 1, 0, 1'b0);
        do_instr(K_BR, 0, 0, 1'b0);
        do_instr(K_ALU, 2, 0, 1'b1);
        tick();
        #1;
        chk_cyc("idle_after_halt", 3'd0, 1'b0, 6'b000000);

        // halt_req in IDLE alongside start must not arm the latch; start outside IDLE ignored.
        halt_req = 1'b1;
        start_seq();
        halt_req = 1'b0;
        start = 1'b1;
        do_instr(K_BR, 0, 0, 1'b0);
        start = 1'b0;
        do_instr(K_LD, 1, 1, 1'b1);

        // Asynchronous reset while waiting in MEM.
        start_seq();
        is_mem = 1'b1; is_store = 1'b1; is_branch = 1'b0;
        im_ready = 1'b1;
        tick();
        im_ready = 1'b0;
        tick();
        tick();
        dm_ready = 1'b0;
        #1;
        chk_cyc("mem_pre_reset", 3'd4, 1'b1, 6'b000011);
        RST_N = 1'b0;
        #1;
        chk_cyc("async_reset", 3'd0, 1'b0, 6'b000000);
        chk("async_reset_retired", {28'd0, retired}, 32'd0);
        sb_q.delete();
        exp_cnt = '0;
        tick();
        RST_N = 1'b1;
        tick();

        // Sixteen ALU instructions wrap the 4-bit counter back to zero.
        start_seq();
        for (int i = 0; i < 16; i++) begin
            do_instr(K_ALU, 0, 0, (i == 15));
        end
        tick();
        chk("wrap_retired", {28'd0, retired}, 32'd0);

        // Instruction memory never answers.
        start_seq();
        im_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk_cyc("timeout_wait", 3'd1, 1'b1, 6'b100000);
            tick();
        end
        start = 1'b1;
        #1;
`ifdef INSTR_SEQ_TIMEOUT_EN
        chk("timeout_state", {29'd0, state}, 32'd7);
        chk("timeout_fault", {30'd0, fault, busy}, 32'd2);
        chk("timeout_strb", {26'd0, im_req, ir_we, pc_we, rb_we, dm_req, dm_we}, 32'd0);
        tick();
        #1;
        chk("fault_sticky", {29'd0, state}, 32'd7);
`else
        chk_cyc("no_timeout", 3'd1, 1'b1, 6'b100000);
        tick();
        tick();
        #1;
        chk_cyc("no_timeout_late", 3'd1, 1'b1, 6'b100000);
`endif
        start = 1'b0;

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the processor datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and handles the wait handshakes with instruction and data memory. It generates the per-stage write strobes that gate the PC, instruction register, register bank and data memory. It sits beside the decode stage and consumes decode class flags, not raw opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT_CYCLES, 16, max wait cycles on a memory handshake (used only with optional feature)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
start  input  1  leave IDLE and begin fetching
halt_req  input  1  request stop at next instruction boundary
is_mem  input  1  decoded instruction accesses data memory
is_store  input  1  decoded memory access is a store (valid with is_mem)
is_branch  input  1  decoded instruction is a branch/jump (no RF write)
im_ready  input  1  instruction memory data valid
dm_ready  input  1  data memory access complete
im_req  output  1  instruction fetch request
ir_we  output  1  latch instruction word into IR
pc_we  output  1  update PC (W_PC)
rb_we  output  1  register bank write (W_RB)
dm_req  output  1  data memory request
dm_we  output  1  data memory write (W_DM)
busy  output  1  sequencer not in IDLE/FAULT
state  output  3  current state encoding
retired  output  CNT_W  retired-instruction count
fault  output  1  memory handshake timeout (optional feature)

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clock CLK, reset RST_N.
- State register is 3 bits. Encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Reset (asynchronous, any time including mid-instruction): state=IDLE, retired=0, halt latch=0, wait counter=0.
- Reset output values: every strobe 0, busy=0, fault=0.
- All outputs decode combinationally from state and the ready/class inputs; there is no extra output register.
- IDLE: all strobes 0. start=1 -> FETCH next cycle.
- FETCH: im_req=1 continuously.
  - im_ready=0: stay in FETCH.
  - im_ready=1: ir_we=1 in the same cycle, then -> DECODE.
- DECODE: exactly 1 cycle, no strobes -> EXEC. Decode flags are valid from this cycle and held stable by IR until the next ir_we.
- EXEC: exactly 1 cycle.
  - is_mem=1 -> MEM.
  - else is_branch=1: pc_we=1, retire, -> boundary.
  - else -> WB.
- MEM: dm_req=1; dm_we=is_store, held for the whole wait.
  - dm_ready=0: stay in MEM.
  - dm_ready=1 with store: pc_we=1, retire, -> boundary.
  - dm_ready=1 with load: -> WB.
- WB: rb_we=1, pc_we=1, retire, -> boundary. Lasts 1 cycle.
- Boundary: next state is IDLE if the halt latch or halt_req is set; otherwise FETCH.
- Halt latch: set by halt_req=1 in any cycle; cleared on entry to IDLE. A halt never aborts an instruction already in flight.
- Retire: retired increments by 1 in the cycle pc_we=1. It wraps modulo 2^CNT_W; all-ones + 1 = 0.
- Instruction latencies, excluding memory wait cycles:
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- start=1 outside IDLE is ignored.
- halt_req=1 while in IDLE: the latch does not set, and start still takes priority.
- busy=1 in FETCH through WB.

Optional Feature:
- Macro: INSTR_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH or MEM and counts each cycle ready=0 while in those states.
  - Reaching TIMEOUT_CYCLES consecutive wait cycles -> FAULT.
  - FAULT: all strobes 0, fault=1, busy=0. It is left only by reset; start is ignored.
  - ready arriving in the same cycle the count reaches the limit wins, and there is no fault.
- Undefined: no counter; waits are unbounded; fault tied to 0; FAULT state unreachable.

Decomposition:
- Shared package: state encodings, STATE_W=3, CNT_W default.
- Sub-module retire_counter (CNT_W-wide, enable, wrap, async active-low clear).
- State machine stays in the top block.

Test Plan:
- ALU instruction, im_ready tied 1, start pulse: states 1,2,3,5,1; ir_we in FETCH; rb_we=pc_we=1 in WB only; retired 0->1.
- Load (is_mem=1, is_store=0), dm_ready delayed 3 cycles: dm_req=1 for 4 cycles, dm_we=0, then WB; retired=1 after 8 cycles from FETCH.
- Store then branch: store gives dm_we=1 with no rb_we; branch gives pc_we in EXEC with rb_we never set; retired=2.
- halt_req pulse during DECODE: instruction completes, then state=IDLE and busy=0; a new start resumes FETCH.
- RST_N low in MEM with dm_req=1: all outputs go 0 asynchronously and state=IDLE; retired preloaded near all-ones then incremented wraps to 0.
- With INSTR_SEQ_TIMEOUT_EN, im_ready=0 for 16 cycles: state=7, fault=1; without the macro the sequencer stays in FETCH.
